mem_fill_ctrl: RTL and testbench

Write-side controller for the 1024-entry sample memory that the min/max scan FSM reads. On a `load` command it accepts a valid/ready word stream and writes it to sequential addresses 0..DEPTH-1 through a registered single-port write interface. When the memory is full it pulses `done` and `scan_start`, and `scan_start` drives the scan FSM `start` input. Composed of a control FSM plus an address/count datapath.

---
 rtl/mem_fill_pkg.sv | 21 ++
 rtl/mem_fill_addr_cnt.sv | 47 ++++
 rtl/mem_fill_ctrl.sv | 147 ++++++++++++++
 tb/tb_mem_fill_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the sample-memory fill controller.
// Also imported by the min/max scan FSM bench.
package mem_fill_pkg;

   localparam int unsigned FILL_DEPTH  = 1024;
   localparam int unsigned FILL_ADDR_W = 10;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      ARM   = 3'd1,
      FILL  = 3'd2,
      FLUSH = 3'd3,
      DONE  = 3'd4
   } fill_state_t;

   // States in which a fill is in progress.
   function automatic logic is_busy(input fill_state_t s);
      return (s == ARM) || (s == FILL) || (s == FLUSH);
   endfunction

endpackage

// File: rtl/mem_fill_addr_cnt.sv
// Write-address counter and written-word counter for one memory fill.
// term_c flags the transfer that takes the address counter past DEPTH-1.
module mem_fill_addr_cnt
   import mem_fill_pkg::*;
#(
   parameter int unsigned DEPTH  = FILL_DEPTH,
   parameter int unsigned ADDR_W = FILL_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              inc,
   input  logic              wr_inc,
   output logic [ADDR_W-1:0] addr,
   output logic [ADDR_W:0]   fill_count,
   output logic              term_c
);

   localparam int unsigned       CNT_W     = ADDR_W + 1;
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   // Address of the next accepted word; advances once per transfer.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr <= '0;
      end else if (clr) begin
         addr <= '0;
      end else if (inc) begin
         addr <= addr + ADDR_W'(1);
      end
   end

   // Words actually written to memory; holds its value after an abort.
   always_ff @(posedge clk) begin
      if (rst) begin
         fill_count <= '0;
      end else if (clr) begin
         fill_count <= '0;
      end else if (wr_inc) begin
         fill_count <= fill_count + CNT_W'(1);
      end
   end

   // Last word of the fill is being accepted this cycle.
   assign term_c = inc && (addr == LAST_ADDR);

endmodule

// File: rtl/mem_fill_ctrl.sv
// Write-side fill controller for the scan FSM's sample memory.
// Accepts a valid/ready stream after `load`, writes DEPTH words to
// addresses 0..DEPTH-1 with one cycle of latency, then pulses done and
// scan_start once the final write has landed.
// Build option: define MEM_FILL_CHECKSUM_EN to add the `checksum` output.
module mem_fill_ctrl
   import mem_fill_pkg::*;
#(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = FILL_DEPTH,
   parameter int unsigned ADDR_W = FILL_ADDR_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     load,
   input  logic                     abort,
   input  logic                     in_valid,
   input  logic [DATA_W-1:0]        in_data,
   output logic                     in_ready,
   output logic                     wr_en,
   output logic [ADDR_W-1:0]        wr_addr,
   output logic [DATA_W-1:0]        wr_data,
   output logic [ADDR_W:0]          fill_count,
   output logic                     busy,
   output logic                     done,
   output logic                     scan_start
`ifdef MEM_FILL_CHECKSUM_EN
   ,
   output logic [DATA_W+ADDR_W-1:0] checksum
`endif
);

   fill_state_t       state;
   fill_state_t       state_nxt;
   logic              xfer_c;
   logic              cnt_clr_c;
   logic              term_c;
   logic              busy_nxt_c;
   logic              done_nxt_c;
   logic [ADDR_W-1:0] cnt_addr;

   // Address and written-word counters.
   mem_fill_addr_cnt #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_addr_cnt (
      .clk        (clk),
      .rst        (rst),
      .clr        (cnt_clr_c),
      .inc        (xfer_c),
      .wr_inc     (wr_en),
      .addr       (cnt_addr),
      .fill_count (fill_count),
      .term_c     (term_c)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; abort wins over every other condition.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (load && !abort) begin
               state_nxt = ARM;
            end
         end
         ARM: begin
            state_nxt = abort ? IDLE : FILL;
         end
         FILL: begin
            if (abort) begin
               state_nxt = IDLE;
            end else if (term_c) begin
               state_nxt = FLUSH;
            end
         end
         FLUSH: begin
            state_nxt = abort ? IDLE : DONE;
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // Output decode: ready masking plus next values of the status registers.
   always_comb begin
      in_ready   = 1'b0;
      cnt_clr_c  = 1'b0;
      busy_nxt_c = 1'b0;
      done_nxt_c = 1'b0;
      in_ready   = (state == FILL) && !abort;
      cnt_clr_c  = (state == ARM);
      busy_nxt_c = is_busy(state_nxt);
      done_nxt_c = (state_nxt == DONE);
   end

   assign xfer_c = in_valid && in_ready;

   // Registered write port and status outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         scan_start <= 1'b0;
      end else begin
         wr_en <= xfer_c;
         if (xfer_c) begin
            wr_addr <= cnt_addr;
            wr_data <= in_data;
         end
         busy       <= busy_nxt_c;
         done       <= done_nxt_c;
         scan_start <= done_nxt_c;
      end
   end

`ifdef MEM_FILL_CHECKSUM_EN
   localparam int unsigned CSUM_W = DATA_W + ADDR_W;

   // Running sum of written words; wide enough for DEPTH maximal words.
   always_ff @(posedge clk) begin
      if (rst) begin
         checksum <= '0;
      end else if (cnt_clr_c) begin
         checksum <= '0;
      end else if (wr_en) begin
         checksum <= checksum + CSUM_W'(wr_data);
      end
   end
`endif

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Directed bench for mem_fill_ctrl: back-to-back fill, throttled fill,
// abort, ignored commands, mid-fill reset and (optional) checksum.
module tb_mem_fill_ctrl;
   import mem_fill_pkg::*;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = FILL_DEPTH;
   localparam int unsigned ADDR_W = FILL_ADDR_W;

   logic                     clk = 1'b0;
   logic                     rst;
   logic                     load;
   logic                     abort;
   logic                     in_valid;
   logic [DATA_W-1:0]        in_data;
   logic                     in_ready;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic [ADDR_W:0]          fill_count;
   logic                     busy;
   logic                     done;
   logic                     scan_start;
`ifdef MEM_FILL_CHECKSUM_EN
   logic [DATA_W+ADDR_W-1:0] checksum;
   int                       exp_csum;
`endif

   int n_err  = 0;
   int n_chk  = 0;
   int n_xfer = 0;

   always #5 clk = ~clk;

   mem_fill_ctrl #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .load       (load),
      .abort      (abort),
      .in_valid   (in_valid),
      .in_data    (in_data),
      .in_ready   (in_ready),
      .wr_en      (wr_en),
      .wr_addr    (wr_addr),
      .wr_data    (wr_data),
      .fill_count (fill_count),
      .busy       (busy),
      .done       (done),
      .scan_start (scan_start)
`ifdef MEM_FILL_CHECKSUM_EN
      ,
      .checksum   (checksum)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 time unit after posedge.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // One FILL-state cycle: offer (v, d), then check the registered write.
   task automatic xfer_cycle(input logic v, input logic [7:0] d);
      in_valid = v;
      in_data  = d;
      #1;
      check("in_ready_fill", 32'(in_ready), 32'd1);
      cyc();
      check("wr_en", 32'(wr_en), 32'(v));
      if (v) begin
         check("wr_addr", 32'(wr_addr), 32'(n_xfer));
         check("wr_data", 32'(wr_data), 32'(d));
         n_xfer++;
      end
   endtask

   // From IDLE: load, pass through ARM, arrive in the first FILL cycle.
   task automatic start_fill(input logic v_in_arm);
      load     = 1'b1;
      in_valid = v_in_arm;
      in_data  = 8'h11;
      cyc();
      load = 1'b0;
      check("arm_busy", 32'(busy), 32'd1);
      check("arm_ready", 32'(in_ready), 32'd0);
      check("arm_wr_en", 32'(wr_en), 32'd0);
      cyc();
      check("fill_cnt_clr", 32'(fill_count), 32'd0);
      check("fill_first_wr_en", 32'(wr_en), 32'd0);
      n_xfer = 0;
   endtask

   // From FLUSH: check the flush cycle, the done pulse and the return to IDLE.
   task automatic expect_done();
      in_valid = 1'b1;
      in_data  = 8'h77;
      #1;
      check("flush_ready", 32'(in_ready), 32'd0);
      check("flush_done", 32'(done), 32'd0);
      check("flush_busy", 32'(busy), 32'd1);
      cyc();
      check("done_pulse", 32'(done), 32'd1);
      check("scan_start_pulse", 32'(scan_start), 32'd1);
      check("done_wr_en", 32'(wr_en), 32'd0);
      check("done_fill_count", 32'(fill_count), 32'd1024);
      check("done_busy", 32'(busy), 32'd0);
`ifdef MEM_FILL_CHECKSUM_EN
      if (exp_csum >= 0) check("done_checksum", 32'(checksum), 32'(exp_csum));
`endif
      in_valid = 1'b0;
      cyc();
      check("post_done", 32'(done), 32'd0);
      check("post_scan_start", 32'(scan_start), 32'd0);
      check("post_ready", 32'(in_ready), 32'd0);
      check("post_fill_count", 32'(fill_count), 32'd1024);
      check("post_wr_en", 32'(wr_en), 32'd0);
`ifdef MEM_FILL_CHECKSUM_EN
      if (exp_csum >= 0) check("held_checksum", 32'(checksum), 32'(exp_csum));
`endif
   endtask

   // Abort from FILL: in_ready masked, IDLE next cycle with no done.
   task automatic abort_fill(input int exp_count);
      abort    = 1'b1;
      in_valid = 1'b1;
      #1;
      check("abort_ready", 32'(in_ready), 32'd0);
      cyc();
      abort    = 1'b0;
      in_valid = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_wr_en", 32'(wr_en), 32'd0);
      check("abort_done", 32'(done), 32'd0);
      check("abort_scan_start", 32'(scan_start), 32'd0);
      check("abort_fill_count", 32'(fill_count), 32'(exp_count));
      cyc();
      check("abort_done_2", 32'(done), 32'd0);
      check("abort_fill_count_2", 32'(fill_count), 32'(exp_count));
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_wr_en"}, 32'(wr_en), 32'd0);
      check({tag, "_wr_addr"}, 32'(wr_addr), 32'd0);
      check({tag, "_wr_data"}, 32'(wr_data), 32'd0);
      check({tag, "_fill_count"}, 32'(fill_count), 32'd0);
      check({tag, "_busy"}, 32'(busy), 32'd0);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_scan_start"}, 32'(scan_start), 32'd0);
      check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
`ifdef MEM_FILL_CHECKSUM_EN
      check({tag, "_checksum"}, 32'(checksum), 32'd0);
`endif
   endtask

   initial begin
      rst      = 1'b1;
      load     = 1'b0;
      abort    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
`ifdef MEM_FILL_CHECKSUM_EN
      exp_csum = -1;
`endif
      cyc();
      cyc();
      check_reset_values("reset");
      rst = 1'b0;

      // Back-to-back fill, data = index[7:0]; sum = 4 * 32640.
      start_fill(1'b1);
      for (int k = 0; k < 1024; k++) xfer_cycle(1'b1, 8'(k));
`ifdef MEM_FILL_CHECKSUM_EN
      exp_csum = 130560;
`endif
      expect_done();

      // Throttled source: valid alternates 1,0,1,0.
`ifdef MEM_FILL_CHECKSUM_EN
      exp_csum = -1;
`endif
      start_fill(1'b0);
      for (int c = 0; n_xfer < 1024; c++) begin
         if (c % 2 == 0) xfer_cycle(1'b1, 8'(n_xfer * 7 + 3));
         else            xfer_cycle(1'b0, 8'hA5);
      end
      expect_done();

      // Abort after 300 transfers.
      start_fill(1'b0);
      for (int k = 0; k < 300; k++) xfer_cycle(1'b1, 8'(k ^ 8'h3C));
      abort_fill(300);

      // load during FILL is ignored: addresses continue without restart.
      start_fill(1'b0);
      for (int k = 0; k < 10; k++) xfer_cycle(1'b1, 8'(k + 1));
      load = 1'b1;
      xfer_cycle(1'b1, 8'h5A);
      load = 1'b0;
      check("load_in_fill_busy", 32'(busy), 32'd1);
      for (int k = 0; k < 5; k++) xfer_cycle(1'b1, 8'(k + 200));
      abort_fill(16);

      // load together with abort in IDLE stays IDLE.
      load  = 1'b1;
      abort = 1'b1;
      cyc();
      load  = 1'b0;
      abort = 1'b0;
      check("ld_ab_busy", 32'(busy), 32'd0);
      check("ld_ab_ready", 32'(in_ready), 32'd0);
      cyc();
      check("ld_ab_busy_2", 32'(busy), 32'd0);
      check("ld_ab_fill_count", 32'(fill_count), 32'd16);

      // Synchronous reset at transfer 500, then a fresh fill from address 0.
      start_fill(1'b0);
      for (int k = 0; k < 500; k++) xfer_cycle(1'b1, 8'(k * 7 + 3));
      rst      = 1'b1;
      in_valid = 1'b1;
      cyc();
      check_reset_values("midrst");
      rst      = 1'b0;
      in_valid = 1'b0;
      cyc();
      check("after_rst_busy", 32'(busy), 32'd0);
      start_fill(1'b0);
      for (int k = 0; k < 5; k++) xfer_cycle(1'b1, 8'(k + 9));
      abort_fill(5);

`ifdef MEM_FILL_CHECKSUM_EN
      // All-0xFF fill: 1024 * 255 = 0x3FC00.
      start_fill(1'b1);
      for (int k = 0; k < 1024; k++) xfer_cycle(1'b1, 8'hFF);
      exp_csum = 32'h3FC00;
      expect_done();
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
